multi_source_data_manager: RTL and testbench
============================================

# multi_source_data_manager

Parametrised N-channel byte merger feeding the single UART transmit path. Each source, such as the keyboard translator or the button encoder, strobes bytes into its own small FIFO. A central FSM arbitrates among the non-empty FIFOs and issues one byte at a time to the transmitter, pacing on its `tx_busy`. Unlike the two-source fixed-priority merger, no byte is lost on simultaneous arrivals, and overflow is reported per channel.

## Interface
- `NUM_CH`, 2: number of source channels (1..8); channel 0 is the highest fixed priority.
- `DATA_W`, 8: byte width.
- `FIFO_DEPTH`, 4: entries per channel FIFO; power of two, at least 2.
- `ROUND_ROBIN`, 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin.

- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-high reset.
- `in_rdy` input NUM_CH: per-channel one-cycle write strobe.
- `in_data` input NUM_CH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
- `tx_busy` input 1: transmitter busy; high while a byte is shifting out.
- `data` output DATA_W: byte to transmit; registered; holds its value between sends.
- `send` output 1: one-cycle pulse; `data` is valid in the same cycle.
- `in_drop` output NUM_CH: registered one-cycle pulse when channel i's strobe hit a full FIFO.
- `fifo_full` output NUM_CH: combinational per-channel full flags.

## Operation
- **Push:** `in_rdy[i]` pushes `in_data[i]` into FIFO i when it is not full.
  - If FIFO i is full and no pop of FIFO i occurs in the same cycle, the byte is discarded and `in_drop[i]` pulses on the next cycle.
  - If FIFO i is full and a pop of FIFO i occurs in the same cycle, the push is accepted and no drop occurs.
- **FSM states:** IDLE, SEND, GUARD, WAIT.
  - IDLE: if `tx_busy`=0 and any FIFO is non-empty, grant one channel, pop its head into `data`, and go to SEND. Otherwise stay in IDLE.
  - SEND: `send`=1 for exactly this cycle; go to GUARD unconditionally.
  - GUARD: one cycle with `send`=0, giving the transmitter time to raise `tx_busy`; go to WAIT.
  - WAIT: stay while `tx_busy`=1; go to IDLE on the first cycle `tx_busy`=0.
- **Fixed priority:** grant the lowest-index non-empty FIFO.
- **Round-robin:** a pointer `last` records the last granted channel. Search from `last`+1 modulo NUM_CH and take the first non-empty FIFO; update `last` only on a grant.
- **FIFO pointers:** read/write pointers have width clog2(FIFO_DEPTH)+1; the extra MSB distinguishes full from empty. Pointers wrap naturally.
- **Reset (asynchronous):** clears all FIFOs, FSM goes to IDLE, `data`=0, `send`=0, `in_drop`=0, `last`=NUM_CH-1 so channel 0 wins first in round-robin. Reset asserted mid-SEND or mid-WAIT aborts immediately; the pending byte is lost.

## Timing
- **Minimum latency:** `in_rdy` sampled at edge k, FIFO non-empty after edge k, IDLE grants at edge k+1, so `send`=1 in the cycle after edge k+1.
- **Minimum spacing:** 4 cycles between `send` pulses (SEND, GUARD, WAIT, IDLE) when `tx_busy` never asserts.
- **Stalled start:** `tx_busy` high while in IDLE blocks a grant; the FSM stays in IDLE.
- **Pulse width:** `send` is never high for two consecutive cycles.

## Structure
- Shared package holds:
  - FSM state typedef (IDLE, SEND, GUARD, WAIT);
  - the clog2-based pointer width function;
  - channel-index width constant `CH_W` = max(1, clog2(NUM_CH)).
- Sub-module `byte_fifo` (parameters DATA_W, FIFO_DEPTH) with ports push, pop, din, dout (head, combinational), full, empty. Instantiate it NUM_CH times in a generate loop.
- Arbiter logic and FSM stay in the top module.

## Test plan
- **Single byte:** NUM_CH=2, `tx_busy`=0, `in_rdy[0]` with 0x41 at edge 1 -> `send`=1 with `data`=0x41 in the cycle after edge 2, then `send`=0 for at least 3 cycles.
- **Simultaneous arrivals:** ch0=0x31 and ch1=0x32 on the same edge, ROUND_ROBIN=0 -> 0x31 sent, then 0x32 four cycles later; no `in_drop`.
- **Round-robin fairness:** ROUND_ROBIN=1, NUM_CH=3, each FIFO preloaded with 2 bytes -> grant order ch0, ch1, ch2, ch0, ch1, ch2.
- **Overflow:** FIFO_DEPTH=4, five strobes on ch1 while `tx_busy`=1 -> `fifo_full[1]`=1 after the 4th strobe, `in_drop[1]` pulses once, and the first 4 bytes are sent in order after `tx_busy` falls.
- **Transmitter pacing:** `tx_busy` goes high in GUARD and stays high for 20 cycles -> the next `send` comes no earlier than 2 cycles after `tx_busy` falls.
- **Mid-operation reset:** assert `reset` in WAIT with 3 bytes queued -> outputs go to zero immediately; after release no `send` occurs until a new `in_rdy`.

Source files
------------

// File: rtl/multi_source_data_manager_pkg.sv
// Shared types and width helpers for the multi-source byte merger.
package multi_source_data_manager_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam int MAX_CH = 8;

  // FIFO pointers carry one extra MSB so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/multi_source_data_manager_byte_fifo.sv
// Small per-channel FIFO with a combinational head; a push into a full FIFO
// is accepted when a pop frees a slot in the same cycle.
module byte_fifo
  import multi_source_data_manager_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int AW = PW - 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/multi_source_data_manager.sv
// N-channel byte merger: per-channel FIFOs, fixed-priority or round-robin
// arbitration, and a SEND/GUARD/WAIT pacing FSM toward the UART transmitter.
module multi_source_data_manager
  import multi_source_data_manager_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ROUND_ROBIN = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_rdy,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     tx_busy,
  output logic [DATA_W-1:0]        data,
  output logic                     send,
  output logic [NUM_CH-1:0]        in_drop,
  output logic [NUM_CH-1:0]        fifo_full
);

  localparam int CH_W = ch_width(NUM_CH);

  state_t              state;
  state_t              state_nx;
  logic [NUM_CH-1:0]   empty;
  logic [NUM_CH-1:0]   pop;
  logic [DATA_W-1:0]   head [NUM_CH];
  logic [DATA_W-1:0]   head_sel;
  logic [CH_W-1:0]     last;
  logic [CH_W-1:0]     grant;
  logic                grant_vld;
  logic                take;
  int                  scan;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
    byte_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (in_rdy[i]),
      .pop  (pop[i]),
      .din  (in_data[i*DATA_W +: DATA_W]),
      .dout (head[i]),
      .full (fifo_full[i]),
      .empty(empty[i])
    );
  end

  // Scan order starts at 0 (fixed) or just past the last grant (round-robin).
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan = (ROUND_ROBIN != 0) ? (int'(last) + 1 + k) % NUM_CH : k;
      for (int j = 0; j < NUM_CH; j++) begin
        if (j == scan && !empty[j] && !grant_vld) begin
          grant_vld = 1'b1;
          grant     = CH_W'(j);
        end
      end
    end
  end

  assign take = (state == ST_IDLE) && !tx_busy && grant_vld;

  always_comb begin
    pop      = '0;
    head_sel = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (grant == CH_W'(j)) begin
        pop[j]   = take;
        head_sel = head[j];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (take) state_nx = ST_SEND;
      ST_SEND:  state_nx = ST_GUARD;
      ST_GUARD: state_nx = ST_WAIT;
      ST_WAIT:  if (!tx_busy) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    send = (state == ST_SEND);
  end

  // last starts at NUM_CH-1 so channel 0 is first in round-robin order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data    <= '0;
      last    <= CH_W'(NUM_CH - 1);
      in_drop <= '0;
    end else begin
      if (take) begin
        data <= head_sel;
        last <= grant;
      end
      in_drop <= in_rdy & fifo_full & ~pop;
    end
  end

endmodule

// File: tb/tb_multi_source_data_manager.sv
// Bench for the byte merger: a fixed-priority 2-channel instance and a
// round-robin 3-channel instance checked against a queue-level model.
module tb_multi_source_data_manager;

  logic        clk;
  logic        reset;
  logic        tx_busy;
  logic [1:0]  rdy_a;
  logic [15:0] din_a;
  logic [7:0]  data_a;
  logic        send_a;
  logic [1:0]  drop_a;
  logic [1:0]  full_a;
  logic [2:0]  rdy_b;
  logic [23:0] din_b;
  logic [7:0]  data_b;
  logic        send_b;
  logic [2:0]  drop_b;
  logic [2:0]  full_b;

  int tests;
  int fails;

  multi_source_data_manager #(
    .NUM_CH(2), .DATA_W(8), .FIFO_DEPTH(4), .ROUND_ROBIN(0)
  ) dut_a (
    .clk(clk), .reset(reset), .in_rdy(rdy_a), .in_data(din_a), .tx_busy(tx_busy),
    .data(data_a), .send(send_a), .in_drop(drop_a), .fifo_full(full_a)
  );

  multi_source_data_manager #(
    .NUM_CH(3), .DATA_W(8), .FIFO_DEPTH(4), .ROUND_ROBIN(1)
  ) dut_b (
    .clk(clk), .reset(reset), .in_rdy(rdy_b), .in_data(din_b), .tx_busy(tx_busy),
    .data(data_b), .send(send_b), .in_drop(drop_b), .fifo_full(full_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-channel byte queues (depth 4) and the four-phase send cycle.
  int         ph     [2];
  int         last_m [2];
  int         cnt    [2][3];
  logic [7:0] mem    [2][3][4];
  logic [7:0] e_data [2];
  logic [2:0] e_drop [2];

  task automatic model_step(input int m, input logic [2:0] r, input logic [23:0] d);
    int n;
    int g;
    int c;
    n = (m == 0) ? 2 : 3;
    g = -1;
    e_drop[m] = 3'b000;
    if (ph[m] == 0) begin
      if (!tx_busy) begin
        for (int k = 0; k < n; k++) begin
          c = (m == 1) ? (last_m[m] + 1 + k) % n : k;
          if (g < 0 && cnt[m][c] > 0) g = c;
        end
      end
      if (g >= 0) begin
        e_data[m] = mem[m][g][0];
        for (int j = 0; j < 3; j++) mem[m][g][j] = mem[m][g][j+1];
        cnt[m][g]--;
        last_m[m] = g;
        ph[m] = 1;
      end
    end else if (ph[m] == 3) begin
      if (!tx_busy) ph[m] = 0;
    end else begin
      ph[m] = ph[m] + 1;
    end
    for (int k = 0; k < n; k++) begin
      if (r[k]) begin
        if (cnt[m][k] < 4) begin
          mem[m][k][cnt[m][k]] = d[k*8 +: 8];
          cnt[m][k]++;
        end else begin
          e_drop[m][k] = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [2:0] exp_full(input int m);
    logic [2:0] f;
    f = 3'b000;
    for (int k = 0; k < 3; k++) f[k] = (cnt[m][k] == 4);
    return f;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        ph[m]     = 0;
        last_m[m] = (m == 0) ? 1 : 2;
        e_data[m] = 8'h00;
        e_drop[m] = 3'b000;
        for (int k = 0; k < 3; k++) cnt[m][k] = 0;
      end
    end else begin
      model_step(0, {1'b0, rdy_a}, {8'h00, din_a});
      model_step(1, rdy_b, din_b);
    end
  end

  // Scoreboard compare, every cycle, away from the active edge.
  logic [2:0] ef;
  always @(negedge clk) begin
    check("send_a", {31'd0, send_a}, {31'd0, ph[0] == 1});
    check("data_a", {24'd0, data_a}, {24'd0, e_data[0]});
    check("drop_a", {30'd0, drop_a}, {30'd0, e_drop[0][1:0]});
    ef = exp_full(0);
    check("full_a", {30'd0, full_a}, {30'd0, ef[1:0]});
    check("send_b", {31'd0, send_b}, {31'd0, ph[1] == 1});
    check("data_b", {24'd0, data_b}, {24'd0, e_data[1]});
    check("drop_b", {29'd0, drop_b}, {29'd0, e_drop[1]});
    ef = exp_full(1);
    check("full_b", {29'd0, full_b}, {29'd0, ef});
  end

  // driver tasks
  int         cyc;
  logic [7:0] d;
  int         ndrop;
  int         nsend;
  logic [7:0] exp_rr [6];

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_send(input int which, input int budget, output int c, output logic [7:0] v);
    c = 0;
    v = 8'h00;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      c++;
      if ((which == 0) ? send_a : send_b) begin
        v = (which == 0) ? data_a : data_b;
        return;
      end
    end
    check("send_timeout", 32'd0, 32'd1);
    c = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0; tx_busy = 1'b0;
    rdy_a = '0; din_a = '0; rdy_b = '0; din_b = '0;
    exp_rr = '{8'hA0, 8'hB0, 8'hC0, 8'hA1, 8'hB1, 8'hC1};
    #1 reset = 1'b1;
    idle(2);
    check("rst_data_a", {24'd0, data_a}, 32'h0);
    check("rst_send_a", {31'd0, send_a}, 32'h0);
    check("rst_full_b", {29'd0, full_b}, 32'h0);
    reset = 1'b0;

    // single byte: strobe before edge 1, send after edge 2, then a gap
    @(negedge clk); rdy_a = 2'b01; din_a = 16'h0041;
    @(negedge clk); rdy_a = 2'b00;
    @(negedge clk);
    check("t1_send", {31'd0, send_a}, 32'd1);
    check("t1_data", {24'd0, data_a}, 32'h41);
    repeat (3) begin
      @(negedge clk);
      check("t1_gap", {31'd0, send_a}, 32'd0);
    end
    idle(3);

    // simultaneous arrivals, fixed priority
    @(negedge clk); rdy_a = 2'b11; din_a = 16'h3231;
    @(negedge clk); rdy_a = 2'b00;
    wait_send(0, 10, cyc, d);
    check("t2_lat", cyc, 32'd1);
    check("t2_first", {24'd0, d}, 32'h31);
    wait_send(0, 10, cyc, d);
    check("t2_space", cyc, 32'd4);
    check("t2_second", {24'd0, d}, 32'h32);
    idle(4);

    // round-robin fairness: two bytes per channel preloaded while stalled
    @(negedge clk); tx_busy = 1'b1; rdy_b = 3'b111; din_b = 24'hC0B0A0;
    @(negedge clk); din_b = 24'hC1B1A1;
    @(negedge clk); rdy_b = 3'b000; tx_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_send(1, 12, cyc, d);
      check("t3_order", {24'd0, d}, {24'd0, exp_rr[i]});
    end
    idle(4);

    // overflow: five strobes on ch1 with the transmitter busy
    @(negedge clk); tx_busy = 1'b1;
    ndrop = 0;
    for (int i = 0; i < 5; i++) begin
      rdy_a = 2'b10;
      din_a = {8'(8'h51 + i), 8'h00};
      @(negedge clk);
      ndrop += int'(drop_a[1]);
      if (i == 2) check("t4_not_full", {31'd0, full_a[1]}, 32'd0);
      if (i == 3) check("t4_full", {31'd0, full_a[1]}, 32'd1);
    end
    rdy_a = 2'b00;
    repeat (2) begin
      @(negedge clk);
      ndrop += int'(drop_a[1]);
    end
    check("t4_drops", ndrop, 32'd1);
    tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_send(0, 12, cyc, d);
      check("t4_order", {24'd0, d}, 32'h51 + i);
    end
    nsend = 0;
    repeat (8) begin
      @(negedge clk);
      nsend += int'(send_a);
    end
    check("t4_no_fifth", nsend, 32'd0);

    // transmitter pacing: busy raised in GUARD for 20 cycles
    @(negedge clk); rdy_a = 2'b11; din_a = 16'h6261;
    @(negedge clk); rdy_a = 2'b00;
    wait_send(0, 10, cyc, d);
    check("t5_first", {24'd0, d}, 32'h61);
    @(negedge clk); tx_busy = 1'b1;
    nsend = 0;
    repeat (20) begin
      @(negedge clk);
      nsend += int'(send_a);
    end
    check("t5_held", nsend, 32'd0);
    tx_busy = 1'b0;
    wait_send(0, 10, cyc, d);
    check("t5_gap", cyc, 32'd2);
    check("t5_second", {24'd0, d}, 32'h62);
    idle(4);

    // mid-operation reset while waiting with three bytes queued
    @(negedge clk); rdy_a = 2'b11; din_a = 16'h7271;
    @(negedge clk); din_a = 16'h7473;
    @(negedge clk); rdy_a = 2'b00;
    check("t6_send", {31'd0, send_a}, 32'd1);
    @(negedge clk); tx_busy = 1'b1;
    idle(2);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_data", {24'd0, data_a}, 32'h0);
    check("t6_rst_send", {31'd0, send_a}, 32'h0);
    @(negedge clk);
    #2 reset = 1'b0; tx_busy = 1'b0;
    nsend = 0;
    repeat (10) begin
      @(negedge clk);
      nsend += int'(send_a);
    end
    check("t6_quiet", nsend, 32'd0);
    rdy_a = 2'b10; din_a = 16'h7A00;
    @(negedge clk); rdy_a = 2'b00;
    wait_send(0, 10, cyc, d);
    check("t6_lat", cyc, 32'd1);
    check("t6_data", {24'd0, d}, 32'h7A);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
